ir_nec_send: RTL and testbench

NEC-format infrared transmitter for the weighing-scale FPGA; the transmit-side counterpart of the IR key-code receiver. On a one-cycle `send` request it captures an 8-bit address and 8-bit command and emits one complete NEC frame on `ir`: leader, 32 data bits LSB-first, stop mark, then an enforced inter-frame gap. Baseband polarity matches what the receiver decodes: idle high, mark low. It drives the IR LED path, or loops back to the receiver for self-test.

---
 rtl/ir_nec_pkg.sv | 28 ++
 rtl/ir_us_tick.sv | 26 ++
 rtl/ir_nec_send.sv | 133 +++++++++++++
 tb/tb_ir_nec_send.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// rtl/ir_nec_pkg.sv - NEC state encoding, default timing and frame packing shared by tx and rx
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD_M = 3'd1,
    ST_LEAD_S = 3'd2,
    ST_BIT_M  = 3'd3,
    ST_BIT_S  = 3'd4,
    ST_STOP_M = 3'd5,
    ST_GAP    = 3'd6
  } nec_state_t;

  localparam int NEC_CLK_PER_US   = 1;
  localparam int NEC_LEADER_MARK  = 9000;
  localparam int NEC_LEADER_SPACE = 4500;
  localparam int NEC_BIT_MARK     = 560;
  localparam int NEC_ZERO_SPACE   = 560;
  localparam int NEC_ONE_SPACE    = 1690;
  localparam int NEC_GAP          = 40000;
  localparam int NEC_CARRIER_HALF = 13;

  // Same layout the receiver unpacks its Code from; bit 0 is transmitted first.
  function automatic logic [31:0] nec_pack(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_us_tick.sv
// rtl/ir_us_tick.sv - clk-to-microsecond prescaler with synchronous clear, one-cycle tick output
module ir_us_tick #(
  parameter int CLK_PER_US = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_US - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_nec_send.sv
// rtl/ir_nec_send.sv - NEC IR frame transmitter; IR_NEC_SEND_CARRIER_EN adds carrier on o_ir_led
module ir_nec_send
  import ir_nec_pkg::*;
#(
  parameter int CLK_PER_US   = NEC_CLK_PER_US,
  parameter int LEADER_MARK  = NEC_LEADER_MARK,
  parameter int LEADER_SPACE = NEC_LEADER_SPACE,
  parameter int BIT_MARK     = NEC_BIT_MARK,
  parameter int ZERO_SPACE   = NEC_ZERO_SPACE,
  parameter int ONE_SPACE    = NEC_ONE_SPACE,
  parameter int GAP          = NEC_GAP,
  parameter int CARRIER_HALF = NEC_CARRIER_HALF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_cmd,
  input  logic       i_send,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ir,
  output logic       o_ir_led
);

  nec_state_t  r_state, w_next;
  logic [31:0] r_shreg;
  logic [5:0]  r_bitcnt;
  logic [15:0] r_us, w_dur;
  logic        r_ir, r_busy, r_done;
  logic        w_tick, w_accept, w_seg_end, w_mark_next;

  assign w_accept = (r_state == ST_IDLE) && i_send;

  ir_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_accept),
    .o_tick (w_tick)
  );

  always_comb begin
    w_dur = 16'd0;
    unique case (r_state)
      ST_LEAD_M:           w_dur = 16'(LEADER_MARK);
      ST_LEAD_S:           w_dur = 16'(LEADER_SPACE);
      ST_BIT_M, ST_STOP_M: w_dur = 16'(BIT_MARK);
      ST_BIT_S:            w_dur = r_shreg[0] ? 16'(ONE_SPACE) : 16'(ZERO_SPACE);
      ST_GAP:              w_dur = 16'(GAP);
      default:             w_dur = 16'd0;
    endcase
  end

  // The segment ends on the tick that completes its last microsecond.
  assign w_seg_end = (r_state != ST_IDLE) && w_tick && (r_us == w_dur - 16'd1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (i_send)    w_next = ST_LEAD_M;
      ST_LEAD_M: if (w_seg_end) w_next = ST_LEAD_S;
      ST_LEAD_S: if (w_seg_end) w_next = ST_BIT_M;
      ST_BIT_M:  if (w_seg_end) w_next = ST_BIT_S;
      ST_BIT_S:  if (w_seg_end) w_next = (r_bitcnt == 6'd31) ? ST_STOP_M : ST_BIT_M;
      ST_STOP_M: if (w_seg_end) w_next = ST_GAP;
      ST_GAP:    if (w_seg_end) w_next = ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  assign w_mark_next = (w_next == ST_LEAD_M) || (w_next == ST_BIT_M) || (w_next == ST_STOP_M);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= 32'd0;
      r_bitcnt <= 6'd0;
      r_us     <= 16'd0;
      r_ir     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ir    <= ~w_mark_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (r_state == ST_GAP) && w_seg_end;
      if (w_accept) begin
        r_shreg  <= nec_pack(i_addr, i_cmd);
        r_bitcnt <= 6'd0;
      end else if ((r_state == ST_BIT_S) && w_seg_end) begin
        r_shreg  <= {1'b0, r_shreg[31:1]};
        r_bitcnt <= r_bitcnt + 6'd1;
      end
      if ((w_next != r_state) || (r_state == ST_IDLE)) begin
        r_us <= 16'd0;
      end else if (w_tick) begin
        r_us <= r_us + 16'd1;
      end
    end
  end

  assign o_ir   = r_ir;
  assign o_busy = r_busy;
  assign o_done = r_done;

`ifdef IR_NEC_SEND_CARRIER_EN
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] r_car_cnt;
  logic          r_led;

  // Phase restarts high on every mark entry so each burst begins identically.
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_mark_next) begin
      r_car_cnt <= '0;
      r_led     <= 1'b0;
    end else if (w_next != r_state) begin
      r_car_cnt <= '0;
      r_led     <= 1'b1;
    end else if (r_car_cnt == HALF_LAST) begin
      r_car_cnt <= '0;
      r_led     <= ~r_led;
    end else begin
      r_car_cnt <= r_car_cnt + 1'b1;
    end
  end

  assign o_ir_led = r_led;
`else
  assign o_ir_led = ~r_ir;
`endif

endmodule

// File: tb/tb_ir_nec_send.sv
// tb/tb_ir_nec_send.sv - self-checking bench for ir_nec_send with scaled-down NEC timing
module tb_ir_nec_send;

  localparam int CPU = 2, LM = 90, LS = 45, BM = 6, ZS = 6, OS = 17, GP = 40, CH = 5;
  localparam int EXP_CYC = (LM + LS + 32 * BM + 16 * OS + 16 * ZS + BM + GP) * CPU;
  localparam int BUDGET = 4000;

  logic       clk = 1'b0, rst = 1'b1, send = 1'b0;
  logic [7:0] addr = 8'd0, cmd = 8'd0;
  logic       busy, done, ir, ir_led;
  int         checks = 0, errors = 0;
  logic       smp_ir[$];

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic [31:0] code;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  ir_nec_send #(
    .CLK_PER_US(CPU), .LEADER_MARK(LM), .LEADER_SPACE(LS), .BIT_MARK(BM),
    .ZERO_SPACE(ZS), .ONE_SPACE(OS), .GAP(GP), .CARRIER_HALF(CH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_cmd(cmd), .i_send(send),
    .o_busy(busy), .o_done(done), .o_ir(ir), .o_ir_led(ir_led)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_code(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] na, nc;
    na = a ^ 8'hFF;
    nc = c ^ 8'hFF;
    return {nc, c, na, a};
  endfunction

  // Sends one frame and records ir per cycle until done; optionally pulses send mid-frame.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input int inject_at,
                           output int lat, output int busy_err, output int led_err);
    int   cyc = 0, mark_ofs = 0;
    logic led_exp;
    lat = -1; busy_err = 0; led_err = 0;
    smp_ir.delete();
    addr = a; cmd = c; send = 1'b1;
    @(posedge clk); @(negedge clk);
    send = 1'b0; addr = ~a; cmd = ~c;
    while (cyc < BUDGET) begin
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      smp_ir.push_back(ir);
      if (busy !== 1'b1) busy_err++;
      if (ir === 1'b0) begin
`ifdef IR_NEC_SEND_CARRIER_EN
        led_exp = ((mark_ofs / CH) % 2) == 0;
`else
        led_exp = 1'b1;
`endif
        mark_ofs++;
      end else begin
        led_exp = 1'b0;
        mark_ofs = 0;
      end
      if (ir_led !== led_exp) led_err++;
      if (cyc == inject_at) begin
        send = 1'b1;
        cmd = 8'h33;
      end else begin
        send = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    send = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [7:0] a, input logic [7:0] c,
                             input logic [31:0] exp_code, input int lat,
                             input int busy_err, input int led_err);
    int          seg[$], run[$];
    int          bad = 0, total = 0, n;
    logic [31:0] mc, got = 32'd0;
    mc = model_code(a, c);
    seg.push_back(LM * CPU);
    seg.push_back(LS * CPU);
    for (int i = 0; i < 32; i++) begin
      seg.push_back(BM * CPU);
      seg.push_back((mc[i] ? OS : ZS) * CPU);
    end
    seg.push_back(BM * CPU);
    seg.push_back(GP * CPU);
    foreach (seg[i]) total += seg[i];
    for (int i = 0; i < smp_ir.size(); i++) begin
      if (i == 0 || smp_ir[i] !== smp_ir[i-1]) run.push_back(1);
      else run[run.size()-1]++;
    end
    n = (run.size() < seg.size()) ? run.size() : seg.size();
    for (int i = 0; i < n; i++) if (run[i] != seg[i]) bad++;
    if (run.size() != seg.size()) bad++;
    for (int i = 0; i < 32; i++)
      if (3 + 2 * i < run.size()) got[i] = run[3 + 2 * i] > ((ZS + OS) * CPU) / 2;
    check({nm, "_latency"}, lat, EXP_CYC);
    check({nm, "_model_len"}, lat, total);
    check({nm, "_first_level"}, (smp_ir.size() > 0) ? smp_ir[0] : 1'bx, 1'b0);
    check({nm, "_seg_errs"}, bad, 0);
    check({nm, "_code"}, got, exp_code);
    check({nm, "_busy_errs"}, busy_err, 0);
    check({nm, "_led_errs"}, led_err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, be, le, idle_bad, falls, prev, cyc;
    logic [7:0] ra, rc;

    vecs[0] = '{8'h00, 8'h16, 32'hE916FF00};
    vecs[1] = '{8'hFF, 8'h00, 32'hFF0000FF};
    vecs[2] = '{8'hA5, 8'h5A, 32'hA55A5AA5};
    vecs[3] = '{8'h12, 8'h34, 32'hCB34ED12};
    vecs[4] = '{8'h01, 8'h80, 32'h7F80FE01};

    // Reset held together with send: reset must win.
    rst = 1'b1; send = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ir", ir, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_led", ir_led, 1'b0);
    rst = 1'b0; send = 1'b0;
    idle_bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (ir !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ir_led !== 1'b0) idle_bad++;
    end
    check("idle_hold", idle_bad, 0);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].addr, vecs[i].cmd, -1, lat, be, le);
      check_frame($sformatf("vec%0d", i), vecs[i].addr, vecs[i].cmd, vecs[i].code, lat, be, le);
      repeat (3) @(negedge clk);
    end

    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      run_frame(ra, rc, -1, lat, be, le);
      check_frame($sformatf("rnd%0d", i), ra, rc, model_code(ra, rc), lat, be, le);
      repeat (1 + $urandom_range(0, 4)) @(negedge clk);
    end

    // Back-to-back: second send presented in the done cycle.
    run_frame(8'h00, 8'hA5, -1, lat, be, le);
    check_frame("b2b_a", 8'h00, 8'hA5, 32'h5AA5FF00, lat, be, le);
    run_frame(8'h3C, 8'hC3, -1, lat, be, le);
    check_frame("b2b_b", 8'h3C, 8'hC3, model_code(8'h3C, 8'hC3), lat, be, le);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);

    // Mid-frame send with a different command is ignored and not queued.
    run_frame(8'h21, 8'h16, 400, lat, be, le);
    check_frame("ignored", 8'h21, 8'h16, model_code(8'h21, 8'h16), lat, be, le);
    idle_bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy !== 1'b0 || ir !== 1'b1 || done !== 1'b0) idle_bad++;
    end
    check("no_queued_frame", idle_bad, 0);

    // Reset during bit 10 abandons the frame without a done pulse.
    addr = 8'h55; cmd = 8'hAA; send = 1'b1;
    @(posedge clk); @(negedge clk);
    send = 1'b0;
    falls = 1; prev = ir; cyc = 0;
    while (falls < 12 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (prev == 1 && ir === 1'b0) falls++;
      prev = ir;
    end
    check("reach_bit10", falls, 12);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_ir", ir, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_led", ir_led, 1'b0);
    rst = 1'b0;
    idle_bad = 0;
    repeat (EXP_CYC + 100) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || ir !== 1'b1) idle_bad++;
    end
    check("midrst_abandon", idle_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
